soc_periph_arbiter: RTL and testbench

SOC_PERIPH_ARBITER -- requirements
Module: soc_periph_arbiter

---
 rtl/ariane_soc_pkg.sv | 25 ++
 rtl/soc_addr_decode.sv | 20 ++
 rtl/soc_periph_arbiter.sv | 140 ++++++++++++++
 tb/tb_soc_periph_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_soc_pkg.sv
// rtl/ariane_soc_pkg.sv - SoC address map, slave enumeration and arbiter state type
package ariane_soc;

    localparam int unsigned NB_PERIPHERALS = 11;

    typedef enum logic [3:0] {
        Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, LlcCfg, DRAM
    } axi_slaves_t;

    // Indexed by axi_slaves_t
    localparam logic [63:0] SOC_BASE [NB_PERIPHERALS] = '{
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000,
        64'h1000_0000, 64'h1800_0000, 64'h2000_0000, 64'h3000_0000,
        64'h4000_0000, 64'h5000_0000, 64'h8000_0000
    };

    localparam logic [63:0] SOC_LEN [NB_PERIPHERALS] = '{
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF,
        64'h0000_1000, 64'h0000_1000, 64'h0080_0000, 64'h0001_0000,
        64'h0000_1000, 64'h0000_1000, 64'h4000_0000
    };

    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} arb_state_t;

endpackage

// File: rtl/soc_addr_decode.sv
// rtl/soc_addr_decode.sv - combinational one-hot decode of a 64-bit address against the SoC map
module soc_addr_decode
    import ariane_soc::*;
(
    input  logic [63:0]               addr,
    output logic [NB_PERIPHERALS-1:0] sel,
    output logic                      hit
);

    // Subtracting only after addr >= base keeps the range test free of wrap-around
    always_comb begin
        sel = '0;
        for (int i = 0; i < NB_PERIPHERALS; i++) begin
            sel[i] = (addr >= SOC_BASE[i]) && ((addr - SOC_BASE[i]) < SOC_LEN[i]);
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/soc_periph_arbiter.sv
// rtl/soc_periph_arbiter.sv - round-robin N-master to single-slave-port arbiter with decode and timeout
module soc_periph_arbiter
    import ariane_soc::*;
#(
    parameter int unsigned NrMasters     = 2,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrMasters-1:0]                 mst_req_i,
    input  logic [NrMasters-1:0][63:0]           mst_addr_i,
    input  logic [NrMasters-1:0]                 mst_we_i,
    input  logic [NrMasters-1:0][DataWidth-1:0]  mst_wdata_i,
    input  logic [NrMasters-1:0][DataWidth/8-1:0] mst_be_i,
    output logic [NrMasters-1:0]                 mst_gnt_o,
    output logic [NrMasters-1:0]                 mst_rvalid_o,
    output logic [DataWidth-1:0]                 mst_rdata_o,
    output logic                                 mst_err_o,
    output logic                                 slv_req_o,
    output logic [NB_PERIPHERALS-1:0]            slv_sel_o,
    output logic [63:0]                          slv_addr_o,
    output logic                                 slv_we_o,
    output logic [DataWidth-1:0]                 slv_wdata_o,
    output logic [DataWidth/8-1:0]               slv_be_o,
    input  logic                                 slv_gnt_i,
    input  logic                                 slv_rvalid_i,
    input  logic [DataWidth-1:0]                 slv_rdata_i,
    input  logic                                 slv_err_i
);

    localparam int unsigned IdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    arb_state_t                 state;
    logic [IdxW-1:0]            rr_ptr, win_idx, cand, idx_q;
    logic                       win_found, in_req, timeout;
    logic [CntW-1:0]            cnt;
    logic [63:0]                addr_q;
    logic                       we_q;
    logic [DataWidth-1:0]       wdata_q, rdata_q;
    logic [BeW-1:0]             be_q;
    logic [NB_PERIPHERALS-1:0]  sel_q, dec_sel;
    logic                       dec_hit, err_q;
    logic [NrMasters-1:0]       rvalid_q;

    // Search starts at rr_ptr, which always points one past the last winner
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            cand = IdxW'((32'(rr_ptr) + i) % NrMasters);
            if (!win_found && mst_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    soc_addr_decode u_decode (
        .addr (mst_addr_i[win_idx]),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign timeout = (cnt == CntW'(TimeoutCycles - 1));
    assign in_req  = (state == REQ);

    assign mst_gnt_o    = (state == IDLE && win_found && rst_ni) ? (NrMasters'(1) << win_idx) : '0;
    assign mst_rvalid_o = rvalid_q;
    assign mst_rdata_o  = rdata_q;
    assign mst_err_o    = err_q;
    assign slv_req_o    = in_req;
    assign slv_sel_o    = in_req ? sel_q   : '0;
    assign slv_addr_o   = in_req ? addr_q  : '0;
    assign slv_we_o     = in_req & we_q;
    assign slv_wdata_o  = in_req ? wdata_q : '0;
    assign slv_be_o     = in_req ? be_q    : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            sel_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        idx_q   <= win_idx;
                        addr_q  <= mst_addr_i[win_idx];
                        we_q    <= mst_we_i[win_idx];
                        wdata_q <= mst_wdata_i[win_idx];
                        be_q    <= mst_be_i[win_idx];
                        sel_q   <= dec_sel;
                        cnt     <= '0;
                        rr_ptr  <= (win_idx == IdxW'(NrMasters - 1)) ? '0 : win_idx + 1'b1;
                        state   <= dec_hit ? REQ : ERR;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (slv_gnt_i)    state <= RSP;
                    else if (timeout) state <= ERR;
                end
                RSP: begin
                    cnt <= cnt + 1'b1;
                    if (slv_rvalid_i) begin
                        rvalid_q <= NrMasters'(1) << idx_q;
                        rdata_q  <= slv_rdata_i;
                        err_q    <= slv_err_i;
                        state    <= IDLE;
                    end else if (timeout) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    rvalid_q <= NrMasters'(1) << idx_q;
                    err_q    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// tb/tb_soc_periph_arbiter.sv - randomized self-checking bench for soc_periph_arbiter
module tb_soc_periph_arbiter;

    localparam int NM = 2;
    localparam int DW = 64;
    localparam int TO = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NM-1:0]          mst_req;
    logic [NM-1:0][63:0]    mst_addr;
    logic [NM-1:0]          mst_we;
    logic [NM-1:0][DW-1:0]  mst_wdata;
    logic [NM-1:0][7:0]     mst_be;
    logic [NM-1:0]          mst_gnt, mst_rvalid;
    logic [DW-1:0]          mst_rdata;
    logic                   mst_err;
    logic                   slv_req;
    logic [10:0]            slv_sel;
    logic [63:0]            slv_addr;
    logic                   slv_we;
    logic [DW-1:0]          slv_wdata;
    logic [7:0]             slv_be;
    logic                   slv_gnt, slv_rvalid, slv_err;
    logic [DW-1:0]          slv_rdata;

    int n_vec = 0;
    int n_mis = 0;
    int rr_last;

    logic [63:0] map_base [11] = '{64'h0, 64'h1_0000, 64'h200_0000, 64'hC00_0000,
        64'h1000_0000, 64'h1800_0000, 64'h2000_0000, 64'h3000_0000,
        64'h4000_0000, 64'h5000_0000, 64'h8000_0000};
    logic [63:0] map_len [11] = '{64'h1000, 64'h1_0000, 64'hC_0000, 64'h3FF_FFFF,
        64'h1000, 64'h1000, 64'h80_0000, 64'h1_0000, 64'h1000, 64'h1000, 64'h4000_0000};

    always #5 clk = ~clk;

    soc_periph_arbiter #(.NrMasters(NM), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mst_req_i(mst_req), .mst_addr_i(mst_addr), .mst_we_i(mst_we),
        .mst_wdata_i(mst_wdata), .mst_be_i(mst_be),
        .mst_gnt_o(mst_gnt), .mst_rvalid_o(mst_rvalid), .mst_rdata_o(mst_rdata), .mst_err_o(mst_err),
        .slv_req_o(slv_req), .slv_sel_o(slv_sel), .slv_addr_o(slv_addr), .slv_we_o(slv_we),
        .slv_wdata_o(slv_wdata), .slv_be_o(slv_be),
        .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata), .slv_err_i(slv_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_target(input logic [63:0] a);
        for (int i = 0; i < 11; i++)
            if (a >= map_base[i] && a - map_base[i] < map_len[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [NM-1:0] mask);
        for (int i = 1; i <= NM; i++)
            if (mask[(rr_last + i) % NM]) return (rr_last + i) % NM;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, mst_gnt, 0);
        check({tag, "_rvalid"}, mst_rvalid, 0);
        check({tag, "_rdata"}, mst_rdata, 0);
        check({tag, "_err"}, mst_err, 0);
        check({tag, "_slvreq"}, slv_req, 0);
        check({tag, "_sel"}, slv_sel, 0);
        check({tag, "_addr"}, slv_addr, 0);
        check({tag, "_we"}, slv_we, 0);
        check({tag, "_wdata"}, slv_wdata, 0);
        check({tag, "_be"}, slv_be, 0);
    endtask

    // One complete transaction from a lone requester; gdly extra cycles before slv_gnt, rdly RSP cycles
    task automatic txn(input int m, input logic [63:0] a, input logic we, input logic [63:0] wd,
                       input logic [7:0] be, input int gdly, input int rdly,
                       input logic [63:0] rd, input logic serr);
        int t;
        logic [10:0] sel_exp;
        t = ref_target(a);
        sel_exp = (t >= 0) ? (11'd1 << t) : 11'd0;
        mst_req[m] = 1'b1; mst_addr[m] = a; mst_we[m] = we; mst_wdata[m] = wd; mst_be[m] = be;
        #1;
        check("txn_gnt", mst_gnt, 64'(1) << m);
        rr_last = m;
        tick();
        mst_req = '0;
        if (t < 0) begin
            check("miss_noreq", slv_req, 0);
            tick();
            check("miss_rvalid", mst_rvalid, 64'(1) << m);
            check("miss_err", mst_err, 1);
            check("miss_rdata", mst_rdata, 0);
        end else begin
            for (int k = 0; k <= gdly; k++) begin
                check("req_on", slv_req, 1);
                check("req_sel", slv_sel, sel_exp);
                check("req_addr", slv_addr, a);
                check("req_we", slv_we, we);
                check("req_wdata", slv_wdata, wd);
                check("req_be", slv_be, be);
                if (k == gdly) slv_gnt = 1'b1;
                tick();
                slv_gnt = 1'b0;
            end
            for (int k = 1; k <= rdly; k++) begin
                check("rsp_noreq", slv_req, 0);
                check("rsp_nosel", slv_sel, 0);
                check("rsp_nopulse", mst_rvalid, 0);
                if (k == rdly) begin
                    slv_rvalid = 1'b1; slv_rdata = rd; slv_err = serr;
                end
                tick();
                slv_rvalid = 1'b0; slv_rdata = '0; slv_err = 1'b0;
            end
            check("hit_rvalid", mst_rvalid, 64'(1) << m);
            check("hit_rdata", mst_rdata, rd);
            check("hit_err", mst_err, serr);
        end
        tick();
        check("pulse_end", mst_rvalid, 0);
    endtask

    function automatic logic [63:0] rand_addr();
        int i;
        logic [63:0] a;
        i = $urandom_range(0, 10);
        case ($urandom_range(0, 4))
            0, 1: a = map_base[i] + 64'($urandom % map_len[i][31:0]);
            2:    a = map_base[i] + map_len[i] - 1;
            3:    a = map_base[i] + map_len[i];
            default: a = {$urandom, $urandom};
        endcase
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NM-1:0] mask;
        logic [NM-1:0] prev_gnt;
        int w;
        rst_n = 1'b0; mst_req = '0; mst_addr = '0; mst_we = '0; mst_wdata = '0; mst_be = '0;
        slv_gnt = 1'b0; slv_rvalid = 1'b0; slv_rdata = '0; slv_err = 1'b0;
        rr_last = NM - 1;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        txn(0, 64'h1000_0000, 1'b0, 64'h0, 8'h0, 0, 2, 64'hDEAD, 1'b0);
        txn(1, 64'h7000_0000, 1'b0, 64'h0, 8'h0, 0, 1, 64'h0, 1'b0);
        txn(0, 64'h1_FFFF, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hF0, 1, 1, 64'h55, 1'b0);
        txn(1, 64'h2_0000, 1'b0, 64'h0, 8'h0, 0, 1, 64'h0, 1'b0);
        txn(0, 64'hBFFF_FFFF, 1'b0, 64'h0, 8'hFF, 2, 3, 64'hCAFE_F00D, 1'b1);

        // Slave accepts nothing: timeout after TO cycles in REQ, late rvalid dropped
        mst_req[1] = 1'b1; mst_addr[1] = 64'h1800_0010; mst_we[1] = 1'b0;
        #1;
        check("to_gnt", mst_gnt, 2'b10);
        rr_last = 1;
        tick();
        mst_req = '0;
        for (int k = 1; k <= TO; k++) begin
            check("to_req", slv_req, 1);
            tick();
        end
        check("to_errstate_noreq", slv_req, 0);
        check("to_errstate_nopulse", mst_rvalid, 0);
        slv_rvalid = 1'b1; slv_rdata = 64'hBAD; slv_err = 1'b0;
        tick();
        check("to_rvalid", mst_rvalid, 2'b10);
        check("to_err", mst_err, 1);
        check("to_rdata", mst_rdata, 0);
        tick();
        slv_rvalid = 1'b0; slv_rdata = '0;
        check("to_late_drop", mst_rvalid, 0);
        tick();
        check("to_late_drop2", mst_rvalid, 0);

        // Reset during RSP abandons the transaction
        mst_req[1] = 1'b1; mst_addr[1] = 64'h1000_0000;
        #1;
        check("rst_gnt", mst_gnt, 2'b10);
        tick();
        mst_req = '0;
        slv_gnt = 1'b1;
        tick();
        slv_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        slv_rvalid = 1'b1; slv_rdata = 64'h77;
        tick();
        slv_rvalid = 1'b0; slv_rdata = '0;
        check_all_zero("rst_after");
        rr_last = NM - 1;

        // Round-robin under contention, with grant coinciding with each response pulse
        prev_gnt = '0;
        for (int r = 0; r < 16; r++) begin
            mask = (r < 8) ? 2'b11 : NM'($urandom_range(1, 3));
            for (int i = 0; i < NM; i++) mst_addr[i] = 64'h7000_0000 + 64'(i * 8);
            mst_req = mask;
            #1;
            w = rr_pick(mask);
            check("rr_gnt", mst_gnt, 64'(1) << w);
            if (r > 0 && r < 8) check("rr_alternate", (mst_gnt == prev_gnt), 0);
            prev_gnt = mst_gnt;
            rr_last = w;
            tick();
            mst_req = '0;
            check("rr_noreq", slv_req, 0);
            tick();
            check("rr_rvalid", mst_rvalid, 64'(1) << w);
            check("rr_err", mst_err, 1);
        end
        tick();

        for (int n = 0; n < 40; n++) begin
            txn($urandom_range(0, NM - 1), rand_addr(), 1'($urandom), {$urandom, $urandom},
                8'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                {$urandom, $urandom}, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
